// File: rtl/pio_program_counter.sv
// pio_program_counter
//   Instruction-memory address register for one PIO state machine. On each
//   rising edge it holds, loads a jump target, wraps from wrap_bottom back to
//   wrap_top, or steps to the next address.
//
//   Ports
//     clk          in   system clock, rising-edge active
//     rst          in   asynchronous active-low reset (pc -> 0)
//     wrap_top     in   first address of the program loop (wrap destination)
//     wrap_bottom  in   last address of the program loop (wrap source)
//     jump         in   jump target address
//     jump_en      in   take jump target when advancing
//     pc_en        in   advance enable; pc holds when low
//     pc           out  current program counter (registered)
module pio_program_counter #(
   parameter int PC_WIDTH = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PC_WIDTH-1:0] wrap_top,
   input  logic [PC_WIDTH-1:0] wrap_bottom,
   input  logic [PC_WIDTH-1:0] jump,
   input  logic                jump_en,
   input  logic                pc_en,
   output logic [PC_WIDTH-1:0] pc
);

   logic [PC_WIDTH-1:0] pc_q, pc_d;

   // Jump beats wrap, so a jump issued from wrap_bottom leaves the loop.
   // The wrap compare uses the live wrap_bottom; no copy is kept, so a
   // changed window applies on the very next edge. Increment is modulo
   // 2^PC_WIDTH by natural overflow.
   always_comb begin
      pc_d = pc_q;
      if (pc_en) begin
         if (jump_en)                  pc_d = jump;
         else if (pc_q == wrap_bottom) pc_d = wrap_top;
         else                          pc_d = pc_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pc_q <= '0;
      else      pc_q <= pc_d;
   end

   assign pc = pc_q;

endmodule

// File: tb/tb_pio_program_counter.sv
// tb_pio_program_counter
//   Directed-vector bench for pio_program_counter. Every expected pc value is
//   hand-computed from the intended behaviour and listed inline.
module tb_pio_program_counter;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] wrap_top, wrap_bottom, jump;
   logic       jump_en, pc_en;
   logic [4:0] pc;

   int checks = 0;
   int errors = 0;

   pio_program_counter #(.PC_WIDTH(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .wrap_top    (wrap_top),
      .wrap_bottom (wrap_bottom),
      .jump        (jump),
      .jump_en     (jump_en),
      .pc_en       (pc_en),
      .pc          (pc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One rising edge, then sample pc 1 time unit later.
   task automatic step(input string tag, input logic [4:0] exp);
      @(posedge clk);
      #1;
      chk(tag, pc, exp);
   endtask

   // Reset pulse, released away from the rising edge.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0; pc_en = 1'b1; jump_en = 1'b0; jump = 5'd0;
      wrap_top = 5'd0; wrap_bottom = 5'd31;

      // Reset held across edges with pc_en=1: pc stays 0.
      for (int i = 0; i < 3; i++) step("reset_hold", 5'd0);

      // Full count 1..31, then natural wrap 31->0 (bottom=31 -> top=0), then 1.
      @(negedge clk); rst = 1'b1;
      for (int i = 0; i < 33; i++) step("seq_count", 5'((i + 1) % 32));

      // Asynchronous reset mid-count at pc=7, no clock edge in between.
      do_reset();
      for (int i = 0; i < 7; i++) step("count_to_7", 5'(i + 1));
      #2 rst = 1'b0;
      #1 chk("async_reset", pc, 5'd0);
      @(negedge clk); rst = 1'b1;

      // Narrow window 4..6 from pc=0.
      wrap_top = 5'd4; wrap_bottom = 5'd6;
      step("win_1", 5'd1); step("win_2", 5'd2); step("win_3", 5'd3);
      step("win_4", 5'd4); step("win_5", 5'd5); step("win_6", 5'd6);
      step("win_wrap4", 5'd4); step("win_5b", 5'd5); step("win_6b", 5'd6);
      step("win_wrap4b", 5'd4);

      // Jump at pc=3 to 20.
      do_reset();
      step("pre_j1", 5'd1); step("pre_j2", 5'd2); step("pre_j3", 5'd3);
      jump_en = 1'b1; jump = 5'd20;
      step("jump_20", 5'd20);
      // Get to wrap_bottom, then jump must override the wrap.
      jump = 5'd6;
      step("jump_6", 5'd6);
      jump = 5'd10;
      step("jump_over_wrap", 5'd10);
      jump_en = 1'b0;
      step("after_jump_inc", 5'd11);

      // Stall at pc=5 with a pending jump: holds for 3 edges.
      jump_en = 1'b1; jump = 5'd5;
      step("jump_5", 5'd5);
      pc_en = 1'b0; jump = 5'd17;
      for (int i = 0; i < 3; i++) step("stall_hold", 5'd5);
      pc_en = 1'b1; jump_en = 1'b0;
      step("stall_release", 5'd6);
      step("stall_then_wrap", 5'd4);

      // Degenerate window 9..9.
      wrap_top = 5'd9; wrap_bottom = 5'd9;
      jump_en = 1'b1; jump = 5'd9;
      step("degen_jump", 5'd9);
      jump_en = 1'b0;
      for (int i = 0; i < 3; i++) step("degen_hold", 5'd9);

      // Jump outside window 4..6: runs 30,31,0..6 then wraps to 4.
      wrap_top = 5'd4; wrap_bottom = 5'd6;
      jump_en = 1'b1; jump = 5'd30;
      step("out_jump_30", 5'd30);
      jump_en = 1'b0;
      step("out_31", 5'd31);
      for (int i = 0; i < 7; i++) step("out_overflow", 5'(i));
      step("out_wrap4", 5'd4);

      // Inverted window top=20 > bottom=3.
      wrap_top = 5'd20; wrap_bottom = 5'd3;
      jump_en = 1'b1; jump = 5'd2;
      step("inv_jump_2", 5'd2);
      jump_en = 1'b0;
      step("inv_3", 5'd3);
      step("inv_wrap20", 5'd20);
      step("inv_21", 5'd21);

      // Live wrap inputs: move wrap_bottom onto current pc -> wraps next edge.
      wrap_bottom = 5'd21; wrap_top = 5'd12;
      step("live_wrap", 5'd12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
